lsp_select_1_compose: RTL
=========================

// Module: lsp_select_1_compose
// PURPOSE
//  G.729 Relspwed first-stage refinement, directly upstream of Lsp_expand_1_pipe.
//  Diff: diff[j] = rbuf[j] - lspcb1[cand][j], for j = 0..NC-1.
//  Search: weighted search over NC1 lspcb2 rows for the lower split (Lsp_select_1), giving tindex1.
//  Compose: writes buf[j] = lspcb1[cand][j] + lspcb2[index][j] for j = 0..NC-1 into the Relspwed buffer.
// PARAMETERS
//  NC          5                  lower-split length (words per row searched/composed)
//  NC1         32                 number of lspcb2 rows searched
//  RBUF_BASE   RELSPWED_RBUF      scratch addr of rbuf[0..9]
//  WEGT_BASE   RELSPWED_WEGT      scratch addr of wegt[0..9]
//  BUF_BASE    RELSPWED_BUF       scratch addr of buf[0..9]; consumed by Lsp_expand_1_pipe
//  CB1_BASE    LSPCB1             const-ROM base of lspcb1[128][10], row stride 10
//  CB2_BASE    LSPCB2             const-ROM base of lspcb2[32][10], row stride 10
// PORTS
//  clk          in   1   system clock, rising edge
//  reset        in   1   asynchronous, active-high
//  start        in   1   one-cycle pulse; accepted only in IDLE
//  cand         in   7   lspcb1 candidate row (cand_cur from Lsp_pre_select), sampled at start
//  scratchAddr  out  11  scratch read address
//  scratchIn    in   32  scratch read data; 16-bit value in [15:0]
//  scratchWAddr out  11  scratch write address
//  scratchOut   out  32  scratch write data; sign-extended 16-bit value
//  scratchWE    out  1   scratch write enable
//  constAddr    out  12  constant-ROM read address
//  constIn      in   32  constant-ROM read data; value in [15:0]
//  index        out  5   winning lspcb2 row (tindex1); valid while done=1
//  done         out  1   high from completion until the next accepted start
// BEHAVIOUR
//  Reset: all outputs 0; FSM returns to IDLE.
//   - Asynchronous and may occur mid-run.
//   - No write completes after reset is asserted.
//   - Internal registers cleared; L_dmin = 0x7FFF_FFFF.
//  Memory timing: scratch and ROM are synchronous. Data is valid the cycle after the address is presented.
//  Address generation: a single pipelined address counter is allowed.
//  FSM states:
//   - IDLE: waits for start. On start, latch cand, clear done, go to LOAD.
//   - LOAD: read rbuf[j], wegt[j] and lspcb1[cand][j] for j = 0..NC-1. Store diff[j] = sub(rbuf, cb1) and w[j] in regs.
//   - SEARCH: for k = 0..NC1-1 and j = 0..NC-1, read lspcb2[k][j]:
//       t = sub(diff[j], cb2); p = mult(w[j], t); L = L_mac(L, p, t). L = 0 at each row start.
//   - CMP: at row end, if L_sub(L, L_dmin) < 0 then L_dmin <= L and idx <= k.
//       Strict less-than: on ties the lowest k wins.
//       If every row saturates to 0x7FFF_FFFF, idx = 0.
//   - COMPOSE: read lspcb1[cand][j] and lspcb2[idx][j]. Write add(cb1, cb2) to BUF_BASE+j for j = 0..NC-1, one write per cycle, scratchWE high only then.
//   - DONE: index <= idx and done <= 1. Both hold until the next start, then IDLE. buf[NC..9] is untouched.
//  Arithmetic: ETSI basic-op bit-exact; 16-bit values saturate to [-32768, 32767].
//   - add/sub: 16-bit saturating.
//   - mult: (a*b)>>15; -32768 * -32768 -> 32767.
//   - L_mac: L + 2*a*b, 32-bit saturating.
//   - L_sub: 32-bit saturating.
//  Address arithmetic: CB1 address = CB1_BASE + cand*10 + j; CB2 address = CB2_BASE + k*10 + j. Computed without multipliers (shift-add).
//  Handshake: start while not IDLE/DONE is ignored.
//  Latency: start -> done at most 8 + NC1*(NC+2) + 2*NC cycles (<= 250 with defaults). Not required to be cycle-exact.
// STRUCTURE
//  Shared constants: base addresses, NC, NC1, M and row stride 10 live in paramList.v, not local literals.
//  Existing basic-op modules are reused: add, sub, mult, L_mac, L_sub.
//  Sub-module lsp_select_1_dist: registered one-term-per-cycle weighted-distance accumulator.
//   - Inputs: diff, w, cb2, clr, en.
//   - Output: 32-bit L.
//  Top level keeps only the FSM, address counters, diff/w regs and the min tracker.
// TESTING
//  Bench pairs the block with Scratch_Memory_Controller plus a test mux, as for the expand stages.
//  1. rbuf = lspcb1[cand] and lspcb2[17][0..4] = 0 -> every row but 17 has L > 0; index = 17.
//     buf[j] = lspcb1[cand][j]; buf[5..9] unchanged.
//  2. Rows 3 and 9 both give the minimum distance -> index = 3 (tie keeps first).
//  3. diff = 32767, cb2 = -32768, w = 32767 -> sub and L_mac saturate; L = 0x7FFF_FFFF. All rows equal -> index 0; no X on outputs.
//  4. Reset pulsed in SEARCH (~60 cycles after start):
//     - done = 0, index = 0, scratchWE = 0 immediately;
//     - no write to BUF_BASE;
//     - a fresh start then completes normally.
//  5. Second start while busy -> ignored; a single done and exactly 5 writes.
//  6. ITU speech vectors speech_lsp_select_1_in/out, 120 frames -> index and buf[0..4] bit-exact every frame.
//     Cascade into Lsp_expand_1_pipe and match speech_lsp_expand_1_out.

Source files
------------

// File: rtl/lsp_select_1_compose_pkg.sv
// Shared constants, state encoding and ETSI basic-op arithmetic for the
// Relspwed first-stage refinement (lsp_select_1_compose and its distance
// accumulator).
//
// Contents:
//   NC, NC1, M, ROW_STRIDE     split length, searched rows, LSP order, ROM row stride
//   RELSPWED_*                 scratch addresses of rbuf, wegt and buf
//   LSPCB1, LSPCB2             constant-ROM bases of the two codebooks
//   stateT                     controller states
//   add16/sub16/mult16         16-bit saturating basic ops
//   lAdd/lSub/lMac             32-bit saturating basic ops
package lsp_select_1_compose_pkg;

  localparam int NC         = 5;
  localparam int NC1        = 32;
  localparam int M          = 10;
  localparam int ROW_STRIDE = M;

  localparam logic [10:0] RELSPWED_RBUF = 11'h100;
  localparam logic [10:0] RELSPWED_WEGT = 11'h10A;
  localparam logic [10:0] RELSPWED_BUF  = 11'h114;

  localparam logic [11:0] LSPCB1 = 12'h000;
  localparam logic [11:0] LSPCB2 = 12'h500;

  // Counter end points, sized to the 4-bit phase counter used by the controller
  localparam logic [3:0]  LAST_TERM   = 4'(NC);
  localparam logic [3:0]  LOAD_LAST   = 4'(2 * NC);
  localparam logic [4:0]  LAST_ROW    = 5'(NC1 - 1);
  localparam logic [11:0] ROW_STEP    = 12'(ROW_STRIDE);
  localparam logic [31:0] L_MAX       = 32'h7FFF_FFFF;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SEARCH,
    CMP,
    COMPOSE,
    DONE
  } stateT;

  function automatic logic [15:0] add16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {a[15], a} + {b[15], b};
    if (s[16] != s[15]) return s[16] ? 16'h8000 : 16'h7FFF;
    return s[15:0];
  endfunction

  function automatic logic [15:0] sub16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {a[15], a} - {b[15], b};
    if (s[16] != s[15]) return s[16] ? 16'h8000 : 16'h7FFF;
    return s[15:0];
  endfunction

  // (a*b)>>15 with the single overflow case -32768 * -32768 pinned to 32767
  function automatic logic [15:0] mult16(input logic [15:0] a, input logic [15:0] b);
    logic signed [31:0] p;
    p = 32'($signed(a)) * 32'($signed(b));
    if (p == 32'sh4000_0000) return 16'h7FFF;
    return p[30:15];
  endfunction

  function automatic logic [31:0] lAdd(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {a[31], a} + {b[31], b};
    if (s[32] != s[31]) return s[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    return s[31:0];
  endfunction

  function automatic logic [31:0] lSub(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {a[31], a} - {b[31], b};
    if (s[32] != s[31]) return s[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    return s[31:0];
  endfunction

  // L + 2*a*b, where the doubled product itself saturates before the add
  function automatic logic [31:0] lMac(input logic [31:0] acc, input logic [15:0] a,
                                       input logic [15:0] b);
    logic signed [31:0] p;
    logic [31:0] prod2;
    p = 32'($signed(a)) * 32'($signed(b));
    if (p == 32'sh4000_0000) prod2 = 32'h7FFF_FFFF;
    else                     prod2 = {p[30:0], 1'b0};
    return lAdd(acc, prod2);
  endfunction

endpackage

// File: rtl/lsp_select_1_compose_dist.sv
// Weighted-distance accumulator for one lspcb2 row, one term per cycle:
//   t = sub(diff, cb2); p = mult(w, t); L = L_mac(L, p, t)
//
// Ports:
//   clk, reset   clock and asynchronous active-high reset
//   clr          clears L (row start); has priority over en
//   en           accumulate the term presented this cycle
//   diff, w      diff[j] and wegt[j] for the current term
//   cb2          lspcb2[k][j] for the current term
//   L            registered 32-bit running distance
module lsp_select_1_compose_dist
  import lsp_select_1_compose_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        en,
  input  logic [15:0] diff,
  input  logic [15:0] w,
  input  logic [15:0] cb2,
  output logic [31:0] L
);

  logic [15:0] term;
  logic [15:0] weighted;

  assign term     = sub16(diff, cb2);
  assign weighted = mult16(w, term);

  // Running distance: cleared at each row start, one MAC per enabled cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      L <= '0;
    end else if (clr) begin
      L <= '0;
    end else if (en) begin
      L <= lMac(L, weighted, term);
    end
  end

endmodule

// File: rtl/lsp_select_1_compose.sv
// G.729 Relspwed first-stage refinement (Lsp_select_1 plus buffer compose).
// Loads diff = rbuf - lspcb1[cand] and the weights, searches the NC1 lspcb2
// rows for the minimum weighted distance over the lower split, then writes
// buf[j] = lspcb1[cand][j] + lspcb2[index][j] for j < NC.
//
// Ports:
//   clk, reset     clock and asynchronous active-high reset
//   start, cand    one-cycle start pulse and lspcb1 row, sampled in IDLE/DONE
//   scratchAddr    scratch read address; scratchIn returns data next cycle
//   scratchWAddr   scratch write address, scratchOut data, scratchWE enable
//   constAddr      constant-ROM read address; constIn returns data next cycle
//   index, done    winning lspcb2 row, valid while done is high
module lsp_select_1_compose
  import lsp_select_1_compose_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [6:0]  cand,
  output logic [10:0] scratchAddr,
  input  logic [31:0] scratchIn,
  output logic [10:0] scratchWAddr,
  output logic [31:0] scratchOut,
  output logic        scratchWE,
  output logic [11:0] constAddr,
  input  logic [31:0] constIn,
  output logic [4:0]  index,
  output logic        done
);

  stateT state;
  stateT nextState;

  // cnt is the single pipelined address counter: the address for term cnt is
  // presented this cycle and the data for term cnt-1 is consumed this cycle
  logic [3:0]  cnt;
  logic [4:0]  kRow;
  logic [11:0] rowBase;
  logic [11:0] cb1Base;
  logic [11:0] bestBase;
  logic [31:0] dmin;
  logic [4:0]  idx;

  logic [15:0] diffR [NC];
  logic [15:0] wR    [NC];
  logic [15:0] cb1R  [NC];

  logic [2:0]  jPrev;
  logic [2:0]  jW;
  logic        distClr;
  logic        distEn;
  logic [15:0] distDiff;
  logic [15:0] distW;
  logic [31:0] distL;
  logic [31:0] cmpDelta;
  logic        cmpLess;
  logic [15:0] composeSum;
  logic        unusedBits;

  assign jPrev      = cnt[2:0] - 3'd1;
  assign jW         = cnt[2:0] - 3'd6;
  assign cmpDelta   = lSub(distL, dmin);
  assign cmpLess    = cmpDelta[31];
  assign unusedBits = ^{scratchIn[31:16], constIn[31:16]};

  lsp_select_1_compose_dist uDist (
    .clk   (clk),
    .reset (reset),
    .clr   (distClr),
    .en    (distEn),
    .diff  (distDiff),
    .w     (distW),
    .cb2   (constIn[15:0]),
    .L     (distL)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next state, read addresses and accumulator controls.  LOAD reads rbuf
  // (with lspcb1) for cnt 0..NC-1, then wegt for cnt NC..2NC-1; SEARCH and
  // COMPOSE read one ROM word per cycle with one extra cycle to drain.
  always_comb begin
    nextState   = state;
    scratchAddr = '0;
    constAddr   = '0;
    distClr     = 1'b0;
    distEn      = 1'b0;
    distDiff    = '0;
    distW       = '0;
    case (state)
      IDLE: begin
        if (start) nextState = LOAD;
      end
      LOAD: begin
        if (cnt < LAST_TERM) begin
          scratchAddr = RELSPWED_RBUF + {7'b0, cnt};
          constAddr   = cb1Base + {8'b0, cnt};
        end else if (cnt < LOAD_LAST) begin
          scratchAddr = RELSPWED_WEGT + {7'b0, cnt - LAST_TERM};
        end
        if (cnt == LOAD_LAST) nextState = SEARCH;
      end
      SEARCH: begin
        if (cnt < LAST_TERM) constAddr = rowBase + {8'b0, cnt};
        if (cnt == 4'd0) begin
          distClr = 1'b1;
        end else begin
          distEn   = 1'b1;
          distDiff = diffR[jPrev];
          distW    = wR[jPrev];
        end
        if (cnt == LAST_TERM) nextState = CMP;
      end
      CMP: begin
        nextState = (kRow == LAST_ROW) ? COMPOSE : SEARCH;
      end
      COMPOSE: begin
        if (cnt < LAST_TERM) constAddr = bestBase + {8'b0, cnt};
        if (cnt == LAST_TERM) nextState = DONE;
      end
      DONE: begin
        if (start) nextState = LOAD;
      end
      default: nextState = IDLE;
    endcase
  end

  // Sum written to buf during COMPOSE; only meaningful once data is in flight
  always_comb begin
    composeSum = '0;
    if (state == COMPOSE && cnt != 4'd0) composeSum = add16(cb1R[jPrev], constIn[15:0]);
  end

  // Datapath: operand capture, row/min tracking and the registered write port.
  // Row bases advance by the stride so no multiplier is needed; cand*10 is
  // formed as (cand<<3) + (cand<<1).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt          <= '0;
      kRow         <= '0;
      rowBase      <= '0;
      cb1Base      <= '0;
      bestBase     <= '0;
      dmin         <= L_MAX;
      idx          <= '0;
      index        <= '0;
      done         <= 1'b0;
      scratchWE    <= 1'b0;
      scratchWAddr <= '0;
      scratchOut   <= '0;
      for (int j = 0; j < NC; j++) begin
        diffR[j] <= '0;
        wR[j]    <= '0;
        cb1R[j]  <= '0;
      end
    end else begin
      scratchWE <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            cb1Base  <= LSPCB1 + {2'b0, cand, 3'b0} + {4'b0, cand, 1'b0};
            done     <= 1'b0;
            cnt      <= '0;
            kRow     <= '0;
            rowBase  <= LSPCB2;
            bestBase <= LSPCB2;
            dmin     <= L_MAX;
            idx      <= '0;
          end
        end
        LOAD: begin
          if (cnt != 4'd0) begin
            if (cnt <= LAST_TERM) begin
              diffR[jPrev] <= sub16(scratchIn[15:0], constIn[15:0]);
              cb1R[jPrev]  <= constIn[15:0];
            end else begin
              wR[jW] <= scratchIn[15:0];
            end
          end
          cnt <= (cnt == LOAD_LAST) ? 4'd0 : cnt + 4'd1;
        end
        SEARCH: begin
          cnt <= (cnt == LAST_TERM) ? 4'd0 : cnt + 4'd1;
        end
        CMP: begin
          // Strict less-than keeps the lowest row on ties
          if (cmpLess) begin
            dmin     <= distL;
            idx      <= kRow;
            bestBase <= rowBase;
          end
          kRow    <= kRow + 5'd1;
          rowBase <= rowBase + ROW_STEP;
        end
        COMPOSE: begin
          if (cnt != 4'd0) begin
            scratchWE    <= 1'b1;
            scratchWAddr <= RELSPWED_BUF + {8'b0, jPrev};
            scratchOut   <= {{16{composeSum[15]}}, composeSum};
          end
          if (cnt == LAST_TERM) begin
            done  <= 1'b1;
            index <= idx;
          end
          cnt <= (cnt == LAST_TERM) ? 4'd0 : cnt + 4'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
